// File: rtl/fir_mac_engine.sv
// fir_mac_engine -- multi-channel, time-multiplexed FIR multiply-accumulate engine.
//
// Each accepted sample is shifted into its channel's delay line, then the
// engine walks taps k = 0..n-1, reading coefficient c[ch][k] from the s2
// port of the FIR coefficient memory (read latency 1) and accumulating
// c[ch][k] * x[ch][k]. The sum is arithmetically right-shifted by the
// latched shift amount and presented on the output stream.
//
// Build option: define FIR_SATURATE_EN to clamp the shifted sum to the
// signed DATA_W range instead of wrapping it. Timing is the same either way.
//
// Ports
//   clk_clk, reset_reset       : clock, synchronous active-high reset
//   in_valid/in_ready          : input handshake
//   in_data, in_channel        : input sample and its channel tag
//   cfg_taps, cfg_shift        : tap count and output shift, sampled on accept
//   out_valid/out_ready        : output handshake
//   out_data, out_channel      : filtered sample and its channel tag
//   mem_*                      : s2 coefficient-memory port (read only)
//   busy                       : high whenever the engine is not idle
//   err_channel                : sticky out-of-range channel flag
module fir_mac_engine #(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int TAPS      = 16,
  parameter  int CHANNELS  = 2,
  parameter  int ACC_W     = 40,
  parameter  int ADDR_W    = 15,
  parameter  int COEF_BASE = 0,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW        = $clog2(TAPS + 1),
  localparam int SW        = $clog2(ACC_W)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [TW-1:0]     cfg_taps,
  input  logic [SW-1:0]     cfg_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              err_channel
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = DATA_W + COEF_W;

  localparam logic [CH_W:0]       P_NCH     = (CH_W + 1)'(CHANNELS);
  localparam logic [TW-1:0]       P_TAPS_T  = TW'(TAPS);
  localparam logic [ADDR_W-1:0]   P_TAPS_A  = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0]   P_BASE    = ADDR_W'(COEF_BASE);
  localparam logic signed [ACC_W-1:0] P_SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LAST = 2'd2, S_OUT = 2'd3} state_t;

  state_t                    r_state, w_next;
  logic                      r_in_ready, r_busy, r_out_valid, r_err, r_cs, r_dvld;
  logic [DATA_W-1:0]         r_out_data;
  logic [CH_W-1:0]           r_out_ch, r_ch;
  logic [ADDR_W-1:0]         r_addr, w_base;
  logic [TW-1:0]             r_n;
  logic [SW-1:0]             r_shift;
  logic [KW-1:0]             r_issue_k, r_dk;
  logic signed [ACC_W-1:0]   r_acc, w_acc_add;
  logic signed [DATA_W-1:0]  r_dline [CHANNELS][TAPS];
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_x;
  logic signed [PW-1:0]      w_prod;
  logic                      w_accept, w_ch_ok, w_start, w_last_issue;
  logic                      w_unused;

  // Upper read-data bits carry no coefficient information.
  assign w_unused = ^mem_readdata[31:COEF_W];

  // Zero requests one tap; requests beyond the delay-line depth are capped.
  function automatic logic [TW-1:0] f_clamp_taps(input logic [TW-1:0] t);
    if (t == '0) begin
      return TW'(1);
    end else if (t > P_TAPS_T) begin
      return P_TAPS_T;
    end else begin
      return t;
    end
  endfunction

  // Scale the accumulator down to the output width (wrap or clamp).
  function automatic logic [DATA_W-1:0] f_scale(input logic signed [ACC_W-1:0] a,
                                                input logic [SW-1:0] sh);
    logic signed [ACC_W-1:0] v;
    v = a >>> sh;
`ifdef FIR_SATURATE_EN
    if (v > P_SAT_HI) begin
      return P_SAT_HI[DATA_W-1:0];
    end else if (v < P_SAT_LO) begin
      return P_SAT_LO[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  assign w_accept     = (r_state == S_IDLE) & in_valid & r_in_ready;
  assign w_ch_ok      = ({1'b0, in_channel} < P_NCH);
  assign w_start      = w_accept & w_ch_ok;
  assign w_last_issue = (r_state == S_RUN) & (TW'(r_issue_k) == (r_n - TW'(1)));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN; else w_next = S_IDLE;
      S_RUN:   if (w_last_issue) w_next = S_LAST; else w_next = S_RUN;
      S_LAST:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE; else w_next = S_OUT;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath combinational terms: base address, product, accumulator update.
  // r_dvld marks a cycle in which readdata belongs to the read issued one
  // cycle earlier for tap r_dk.
  always_comb begin
    w_base = P_BASE + ADDR_W'(in_channel) * P_TAPS_A;
    w_coef = $signed(mem_readdata[COEF_W-1:0]);
    w_x    = r_dline[r_ch][r_dk];
    w_prod = w_coef * w_x;
    if (r_dvld) begin
      w_acc_add = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    end else begin
      w_acc_add = r_acc;
    end
  end

  // State register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // Registered control, memory port, accumulator and output stream.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_err       <= 1'b0;
      r_cs        <= 1'b0;
      r_addr      <= '0;
      r_issue_k   <= '0;
      r_dvld      <= 1'b0;
      r_dk        <= '0;
      r_n         <= TW'(1);
      r_shift     <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
    end else begin
      r_in_ready <= (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
      r_dvld     <= (r_state == S_RUN);
      r_dk       <= r_issue_k;
      if (w_accept & ~w_ch_ok) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_ch      <= in_channel;
            r_n       <= f_clamp_taps(cfg_taps);
            r_shift   <= cfg_shift;
            r_acc     <= '0;
            r_addr    <= w_base;
            r_issue_k <= '0;
            r_cs      <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_add;
          if (w_last_issue) begin
            r_cs <= 1'b0;
          end else begin
            r_addr    <= r_addr + ADDR_W'(1);
            r_issue_k <= r_issue_k + KW'(1);
          end
        end
        S_LAST: begin
          r_acc       <= w_acc_add;
          r_out_valid <= 1'b1;
          r_out_data  <= f_scale(w_acc_add, r_shift);
          r_out_ch    <= r_ch;
        end
        S_OUT: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel delay lines; only an accepted in-range sample shifts one.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          r_dline[c][k] <= '0;
        end
      end
    end else if (w_start) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        r_dline[in_channel][k] <= r_dline[in_channel][k-1];
      end
      r_dline[in_channel][0] <= in_data;
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_channel    = r_out_ch;
  assign err_channel    = r_err;
  assign mem_address    = r_addr;
  assign mem_chipselect = r_cs;
  assign mem_clken      = r_cs;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Testbench for fir_mac_engine. Built with three channels so that a 2-bit
// channel tag can address an out-of-range channel (3).
module tb_fir_mac_engine;
  localparam int NCH = 3;
  localparam int TP  = 16;

  logic        clk = 1'b0;
  logic        reset_reset, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [1:0]  in_channel, out_channel;
  logic [4:0]  cfg_taps;
  logic [5:0]  cfg_shift;
  logic [14:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write, busy, err_channel;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_rd = 32'h0;
  logic [31:0] mem [0:NCH*TP-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dl [NCH][TP];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient memory s2 port, one-cycle read latency.
  always @(posedge clk) begin
    int a;
    a = int'(mem_address);
    if (mem_chipselect && mem_clken) mem_rd <= (a < NCH*TP) ? mem[a] : 32'h0;
  end

  fir_mac_engine #(.CHANNELS(NCH)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_channel(in_channel),
    .cfg_taps(cfg_taps), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_readdata(mem_rd),
    .busy(busy), .err_channel(err_channel)
  );

  // ---------------- reference model ----------------
  task automatic set_coef(input int ch, input int k, input logic [15:0] v);
    mem[ch*TP+k] = {16'($urandom()), v};
  endtask

  function automatic void m_clear();
    for (int c = 0; c < NCH; c++) for (int k = 0; k < TP; k++) dl[c][k] = 0;
  endfunction

  function automatic void m_accept(input int ch, input logic [15:0] d);
    for (int k = TP - 1; k > 0; k--) dl[ch][k] = dl[ch][k-1];
    dl[ch][0] = int'($signed(d));
  endfunction

  function automatic int m_taps(input int taps);
    return (taps == 0) ? 1 : ((taps > TP) ? TP : taps);
  endfunction

  function automatic logic [15:0] m_out(input int ch, input int taps, input int sh);
    longint s;
    logic [63:0] r;
    s = 0;
    for (int k = 0; k < m_taps(taps); k++)
      s += longint'($signed(mem[ch*TP+k][15:0])) * longint'(dl[ch][k]);
    s = s >>> sh;
`ifdef FIR_SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    r = s;
    return r[15:0];
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic accept(input logic [1:0] ch, input logic [15:0] d, input int taps,
                        input int sh, output int acc_cyc, output bit tmo);
    tmo = 1'b1;
    acc_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin tmo = 1'b0; break; end
    end
    if (!tmo) begin
      in_valid = 1'b1; in_channel = ch; in_data = d;
      cfg_taps = 5'(taps); cfg_shift = 6'(sh);
      @(posedge clk);
      acc_cyc = cyc;
      #1 in_valid = 1'b0;
    end
  endtask

  // Waits for out_valid; lat counts cycles after the accept edge. Finishes
  // on the following edge, which is the transfer when out_ready is high.
  task automatic wait_out(output logic [15:0] od, output logic [1:0] oc,
                          output int lat, output bit tmo);
    tmo = 1'b1; lat = 0; od = 16'h0; oc = 2'd0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; od = out_data; oc = out_channel; tmo = 1'b0; break; end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < NCH*TP; i++) mem[i] = $urandom();
    m_clear();
    reset_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = 16'h0; in_channel = 2'd0; cfg_taps = 5'd1; cfg_shift = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, err_channel, mem_chipselect, mem_clken, mem_write} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000000",
               {in_ready, out_valid, busy, err_channel, mem_chipselect, mem_clken, mem_write});
    end
    checks++;
    if ({out_data, out_channel, mem_address, mem_byteenable} !== {16'h0, 2'd0, 15'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_values got data %h ch %0d addr %h be %h exp 0 0 0 f",
               out_data, out_channel, mem_address, mem_byteenable);
    end
    reset_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rise got %b exp 1", in_ready); end
  endtask

  task automatic test_impulse();
    logic [15:0] feed [5] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] expv [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    logic [15:0] od; logic [1:0] oc; int lat, ac, prev; bit t1, t2;
    for (int k = 0; k < TP; k++) set_coef(0, k, 16'(k + 1));
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      accept(2'd0, feed[i], 4, 0, ac, t1);
      m_accept(0, feed[i]);
      wait_out(od, oc, lat, t2);
      checks++;
      if ({t1, t2} !== 2'b00 || od !== expv[i] || oc !== 2'd0) begin
        errors++;
        $display("FAIL impulse[%0d] got data %h ch %0d tmo %b%b exp data %h ch 0", i, od, oc, t1, t2, expv[i]);
      end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL impulse_latency[%0d] got %0d exp 6", i, lat); end
      if (i > 0) begin
        checks++;
        if (ac - prev !== 7) begin errors++; $display("FAIL impulse_throughput[%0d] got %0d exp 7", i, ac - prev); end
      end
      prev = ac;
    end
  endtask

  task automatic test_interleaved();
    logic [1:0]  chs  [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [15:0] feed [4] = '{16'd5, 16'd7, 16'd5, 16'd7};
    logic [15:0] expv [4] = '{16'd5, 16'd14, 16'd10, 16'd28};
    logic [15:0] od; logic [1:0] oc; int lat, ac; bit t1, t2;
    for (int k = 0; k < TP; k++) begin set_coef(0, k, 16'd1); set_coef(1, k, 16'd2); end
    for (int i = 0; i < 4; i++) begin
      accept(chs[i], feed[i], 3, 0, ac, t1);
      m_accept(int'(chs[i]), feed[i]);
      wait_out(od, oc, lat, t2);
      checks++;
      if ({t1, t2} !== 2'b00 || od !== expv[i] || oc !== chs[i] || lat !== 5) begin
        errors++;
        $display("FAIL interleave[%0d] got data %0d ch %0d lat %0d exp data %0d ch %0d lat 5",
                 i, od, oc, lat, expv[i], chs[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] od; logic [1:0] oc; int lat, ac; bit t1, t2;
    logic [15:0] e1, e2;
`ifdef FIR_SATURATE_EN
    e1 = 16'h7FFF; e2 = 16'h7FFF;
`else
    e1 = 16'h0001; e2 = 16'h0002;
`endif
    set_coef(2, 0, 16'h7FFF); set_coef(2, 1, 16'h7FFF);
    accept(2'd2, 16'h7FFF, 2, 0, ac, t1); m_accept(2, 16'h7FFF);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== e1) begin errors++; $display("FAIL overflow_first got %h exp %h", od, e1); end
    accept(2'd2, 16'h7FFF, 2, 0, ac, t1); m_accept(2, 16'h7FFF);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== e2 || oc !== 2'd2) begin
      errors++; $display("FAIL overflow_second got %h ch %0d exp %h ch 2", od, oc, e2);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] od, d, e; logic [1:0] oc; int lat, ac; bit t1, t2, stable;
    d = 16'($urandom());
    out_ready = 1'b0;
    accept(2'd1, d, 5, 2, ac, t1); m_accept(1, d);
    e = m_out(1, 5, 2);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== e || oc !== 2'd1 || lat !== 7) begin
      errors++; $display("FAIL bp_result got data %h ch %0d lat %0d exp data %h ch 1 lat 7", od, oc, lat, e);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== e || out_channel !== 2'd1 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable exp stable"); end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid %b ready %b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_bad_channel();
    logic [15:0] od, d, e; logic [1:0] oc; int lat, ac; bit t1, t2, quiet;
    accept(2'd3, 16'($urandom()), 4, 0, ac, t1);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mem_chipselect !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (t1 !== 1'b0 || quiet !== 1'b1) begin errors++; $display("FAIL badch_quiet got activity exp none"); end
    checks++;
    if (err_channel !== 1'b1) begin errors++; $display("FAIL badch_err got %b exp 1", err_channel); end
    d = 16'($urandom());
    accept(2'd0, d, 6, 1, ac, t1); m_accept(0, d);
    e = m_out(0, 6, 1);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== e || oc !== 2'd0) begin
      errors++; $display("FAIL badch_next got %h ch %0d exp %h ch 0", od, oc, e);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] od, e; logic [1:0] oc; int lat, ac; bit t1, t2, never;
    for (int k = 0; k < TP; k++) set_coef(0, k, 16'(k + 1));
    accept(2'd0, 16'h0123, 8, 0, ac, t1);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_address !== 15'd2 || mem_chipselect !== 1'b1) begin
      errors++; $display("FAIL midrun_addr got %h cs %b exp 2 1", mem_address, mem_chipselect);
    end
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;
    m_clear();
    checks++;
    if (err_channel !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got err %b rdy %b busy %b exp 0 0 0", err_channel, in_ready, busy);
    end
    never = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid !== 1'b0) never = 1'b0; end
    checks++;
    if (never !== 1'b1) begin errors++; $display("FAIL midrun_no_output got out_valid exp none"); end
    accept(2'd0, 16'd1, 4, 0, ac, t1); m_accept(0, 16'd1);
    e = m_out(0, 4, 0);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== 16'd1 || od !== e) begin
      errors++; $display("FAIL midrun_impulse0 got %h exp 0001", od);
    end
    accept(2'd0, 16'd0, 4, 0, ac, t1); m_accept(0, 16'd0);
    wait_out(od, oc, lat, t2);
    checks++;
    if ({t1, t2} !== 2'b00 || od !== 16'd2) begin errors++; $display("FAIL midrun_impulse1 got %h exp 0002", od); end
  endtask

  task automatic test_random();
    logic [15:0] od, d, e; logic [1:0] oc, ch; int lat, ac, taps, sh; bit t1, t2;
    for (int i = 0; i < NCH*TP; i++) mem[i] = $urandom();
    for (int i = 0; i < 40; i++) begin
      ch   = 2'($urandom_range(0, NCH - 1));
      d    = 16'($urandom());
      taps = $urandom_range(0, 31);
      sh   = $urandom_range(0, 24);
      accept(ch, d, taps, sh, ac, t1);
      m_accept(int'(ch), d);
      e = m_out(int'(ch), taps, sh);
      wait_out(od, oc, lat, t2);
      checks++;
      if ({t1, t2} !== 2'b00 || od !== e || oc !== ch || lat !== m_taps(taps) + 2) begin
        errors++;
        $display("FAIL random[%0d] got data %h ch %0d lat %0d exp data %h ch %0d lat %0d (taps %0d sh %0d)",
                 i, od, oc, lat, e, ch, m_taps(taps) + 2, taps, sh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_interleaved();
    test_overflow();
    test_backpressure();
    test_bad_channel();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
